cache_arbiter: RTL and testbench

Shares the single physical-memory port between the instruction cache and the data cache of the LC-3b pipelined datapath. It accepts line-sized read requests from the I-cache and read or write requests from the D-cache. It grants one requester at a time, latches that requester's address and write data, and drives the memory port until the memory responds. It then returns the response to the granted requester only.

---
 rtl/cache_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between I-cache and D-cache.
// One grant per transaction; address/data latched at grant, response routed back to the winner.
module cache_arbiter #(
  parameter int addr_width = 16,
  parameter int line_width = 128
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_read,
  input  logic [addr_width-1:0] i_address,
  output logic [line_width-1:0] i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [addr_width-1:0] d_address,
  input  logic [line_width-1:0] d_wdata,
  output logic [line_width-1:0] d_rdata,
  output logic                  d_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [addr_width-1:0] pmem_address,
  output logic [line_width-1:0] pmem_wdata,
  input  logic [line_width-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  state_t                  state;
  state_t                  state_n;
  grant_t                  last_grant;
  grant_t                  last_grant_n;
  logic [addr_width-1:0]   addr_q;
  logic [addr_width-1:0]   addr_n;
  logic [line_width-1:0]   wdata_q;
  logic [line_width-1:0]   wdata_n;
  logic                    write_q;
  logic                    write_n;

  logic i_req;
  logic d_req;
  logic take_i;
  logic take_d;
  logic serving;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On contention the side that did not win last time gets the port.
  assign take_d = d_req && (!i_req || (last_grant == GRANT_I));
  assign take_i = i_req && !take_d;

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    write_n      = write_q;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_d) begin
          state_n      = SERVE_D;
          last_grant_n = GRANT_D;
          addr_n       = d_address;
          wdata_n      = d_wdata;
          write_n      = d_write;
        end else if (take_i) begin
          state_n      = SERVE_I;
          last_grant_n = GRANT_I;
          addr_n       = i_address;
          write_n      = 1'b0;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_resp  = 1'b1;
          state_n = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_resp  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      write_q    <= write_n;
    end
  end

  assign serving      = (state != IDLE);
  assign pmem_read    = serving & ~write_q;
  assign pmem_write   = serving & write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_cache_arbiter;

  logic         clk;
  logic         reset;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter #(
    .addr_width(16),
    .line_width(128)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0 = port free, 1 = I-cache, 2 = D-cache.
  int           m_owner = 0;
  int           m_last  = 1;
  int           m_pick  = 0;
  logic [15:0]  m_addr  = '0;
  logic [127:0] m_wdata = '0;
  logic         m_write = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = 0;
      m_last  = 1;
      m_addr  = '0;
      m_wdata = '0;
      m_write = 1'b0;
    end else if (m_owner != 0) begin
      if (pmem_resp) m_owner = 0;
    end else begin
      m_pick = 0;
      if (i_read && (d_read || d_write)) m_pick = (m_last == 1) ? 2 : 1;
      else if (i_read)                   m_pick = 1;
      else if (d_read || d_write)        m_pick = 2;
      if (m_pick == 1) begin
        m_owner = 1;
        m_last  = 1;
        m_addr  = i_address;
        m_write = 1'b0;
      end else if (m_pick == 2) begin
        m_owner = 2;
        m_last  = 2;
        m_addr  = d_address;
        m_wdata = d_wdata;
        m_write = d_write;
      end
    end
  end

  bit i_saw = 0;
  bit d_saw = 0;

  always @(negedge clk) begin
    check("pmem_read",    128'(pmem_read),    128'((m_owner != 0) && !m_write));
    check("pmem_write",   128'(pmem_write),   128'((m_owner != 0) && m_write));
    check("pmem_address", 128'(pmem_address), 128'(m_addr));
    check("pmem_wdata",   pmem_wdata,         m_wdata);
    check("i_resp",       128'(i_resp),       128'((m_owner == 1) && pmem_resp && !reset));
    check("d_resp",       128'(d_resp),       128'((m_owner == 2) && pmem_resp && !reset));
    check("i_rdata",      i_rdata,            pmem_rdata);
    check("d_rdata",      d_rdata,            pmem_rdata);
    i_saw = i_resp;
    d_saw = d_resp;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] pat_a5;
  logic [127:0] pat_wd;
  logic [15:0]  exp_a;
  bit           strobe;
  int           lat;

  initial begin
    pat_a5     = {16{8'hA5}};
    pat_wd     = 128'h0123456789ABCDEF0123456789ABCDEF;
    reset      = 1'b1;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst pmem_read",  128'(pmem_read),    128'(0));
    check("rst pmem_write", 128'(pmem_write),   128'(0));
    check("rst address",    128'(pmem_address), 128'(0));
    check("rst wdata",      pmem_wdata,         128'(0));

    // I-cache read
    i_read    = 1'b1;
    i_address = 16'h1230;
    tick();
    check("i rd strobe", 128'(pmem_read),    128'(1));
    check("i rd addr",   128'(pmem_address), 128'(16'h1230));
    pmem_rdata = pat_a5;
    pmem_resp  = 1'b1;
    #1;
    check("i rd resp",  128'(i_resp), 128'(1));
    check("i rd data",  i_rdata,      pat_a5);
    check("i rd dresp", 128'(d_resp), 128'(0));
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    check("i rd done", 128'(pmem_read), 128'(0));

    // D-cache write-back, latency 3
    d_write   = 1'b1;
    d_address = 16'h4000;
    d_wdata   = pat_wd;
    tick();
    check("d wr write", 128'(pmem_write), 128'(1));
    check("d wr read",  128'(pmem_read),  128'(0));
    check("d wr data",  pmem_wdata,       pat_wd);
    tick();
    tick();
    check("d wr early", 128'(d_resp), 128'(0));
    pmem_resp = 1'b1;
    #1;
    check("d wr resp", 128'(d_resp), 128'(1));
    tick();
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    #1;
    check("d wr single", 128'(d_resp), 128'(0));

    // Requester drops and changes address after grant
    d_read    = 1'b1;
    d_address = 16'h5550;
    tick();
    tick();
    d_address = 16'h7770;
    d_read    = 1'b0;
    #1;
    check("drop addr", 128'(pmem_address), 128'(16'h5550));
    check("drop strobe", 128'(pmem_read), 128'(1));
    tick();
    pmem_resp = 1'b1;
    #1;
    check("drop resp", 128'(d_resp), 128'(1));
    tick();
    pmem_resp = 1'b0;

    // Read and write together act as a write
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 16'h6000;
    tick();
    check("rw write", 128'(pmem_write), 128'(1));
    check("rw read",  128'(pmem_read),  128'(0));
    pmem_resp = 1'b1;
    #1;
    check("rw resp", 128'(d_resp), 128'(1));
    tick();
    pmem_resp = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;

    // Reset two cycles into SERVE_I
    i_read    = 1'b1;
    i_address = 16'h1230;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("mid rst read", 128'(pmem_read), 128'(0));
    i_read = 1'b0;
    tick();
    reset = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("stray iresp", 128'(i_resp), 128'(0));
    check("stray dresp", 128'(d_resp), 128'(0));
    tick();
    pmem_resp = 1'b0;

    // Continuous contention, latency 3: D, I, D, I
    i_read    = 1'b1;
    i_address = 16'h1111;
    d_read    = 1'b1;
    d_address = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0) ? 16'h2222 : 16'h1111;
      tick();
      check("rr strobe", 128'(pmem_read),    128'(1));
      check("rr addr",   128'(pmem_address), 128'(exp_a));
      tick();
      tick();
      pmem_resp = 1'b1;
      #1;
      check("rr dresp", 128'(d_resp), 128'(k % 2 == 0));
      check("rr iresp", 128'(i_resp), 128'(k % 2 == 1));
      tick();
      pmem_resp = 1'b0;
      check("rr gap", 128'(pmem_read), 128'(0));
    end
    i_read = 1'b0;
    d_read = 1'b0;
    tick();

    // Random traffic against the model
    lat = $urandom_range(0, 3);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 499) == 0);
      pmem_resp = 1'b0;
      strobe    = pmem_read | pmem_write;
      if (strobe) begin
        if (lat == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
          lat        = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (i_read && (i_saw || $urandom_range(0, 39) == 0)) begin
        i_read = 1'b0;
      end else if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read    = 1'b1;
        i_address = 16'($urandom);
      end
      if ((d_read || d_write) && (d_saw || $urandom_range(0, 39) == 0)) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
        d_read    = $urandom_range(0, 1) == 1;
        d_write   = !d_read || ($urandom_range(0, 3) == 0);
        d_address = 16'($urandom);
        d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      if ($urandom_range(0, 7) == 0) begin
        i_address = 16'($urandom);
        d_address = 16'($urandom);
        d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
